power_gate_controller: RTL and testbench

- Per-peripheral clock-gating sequencer, directly downstream of the activity counter.
- Consumes each peripheral's idle_count and recent_activity flag.
- Decides when a peripheral has been idle long enough to gate its clock, then runs a request/acknowledge handshake with the clock-gate cell.
- Wakes the peripheral on demand or when it is disabled.

---
 rtl/power_gate_controller.sv | 164 ++++++++++++++++
 tb/tb_power_gate_controller.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/power_gate_controller.sv
`default_nettype none
// ============================================================================
// Module      : power_gate_controller
// Description : Per-peripheral clock-gating sequencer. Watches each
//               peripheral's idle count and activity flag, requests the
//               clock-gate cell to stop the clock once the peripheral has
//               been idle for idle_threshold cycles, and restarts it on a
//               wake request or when the peripheral is disabled.
//               Each gate transition is a request/acknowledge handshake
//               bounded by ACK_TIMEOUT cycles.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : N           number of peripherals
//               W           idle count / threshold width
//               ACK_TIMEOUT max cycles to wait for gate_ack (>= 1)
// Ports       : clk             system clock
//               rst_n           asynchronous active-low reset
//               idle_count      [N-1:0][W-1:0] idle cycles per peripheral
//               recent_activity [N-1:0] recent-activity flags
//               periph_en       [N-1:0] peripheral enables
//               wake_req        [N-1:0] level wake requests
//               idle_threshold  [W-1:0] gating threshold, 0 = never gate
//               gate_ack        [N-1:0] gate status, 1 = clock running
//               gate_en         [N-1:0] gate enable, 1 = run clock
//               gated           [N-1:0] peripheral is fully gated
//               ack_err         [N-1:0] sticky handshake timeout flags
//               gate_count      [N-1:0][7:0] saturating gate-event counts
//                               (only when POWER_GATE_STATS_EN is defined)
// Options     : POWER_GATE_STATS_EN adds the gate_count statistics output.
// ============================================================================
module power_gate_controller #(
    parameter int N           = 4,
    parameter int W           = 16,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0][W-1:0] idle_count,
    input  logic [N-1:0]        recent_activity,
    input  logic [N-1:0]        periph_en,
    input  logic [N-1:0]        wake_req,
    input  logic [W-1:0]        idle_threshold,
    input  logic [N-1:0]        gate_ack,
    output logic [N-1:0]        gate_en,
    output logic [N-1:0]        gated,
`ifdef POWER_GATE_STATS_EN
    output logic [N-1:0][7:0]   gate_count,
`endif
    output logic [N-1:0]        ack_err
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    // The counter holds the number of completed waiting cycles; the
    // ACK_TIMEOUT-th waiting cycle is the one that observes this value.
    localparam logic [TW-1:0] C_TO_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] C_TO_SAT  = TW'(ACK_TIMEOUT);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_GATED = 2'd2,
        S_WAKE  = 2'd3
    } state_t;

    // Threshold zero disables gating globally.
    logic w_thr_valid;
    assign w_thr_valid = (idle_threshold != '0);

    for (genvar gi = 0; gi < N; gi++) begin : g_periph
        state_t        r_state;
        state_t        w_next;
        logic [TW-1:0] r_cnt;
        logic          r_gate_en;
        logic          r_gated;
        logic          r_ack_err;
        logic          w_go_idle;
        logic          w_timeout;
        logic          w_set_err;
        logic          w_wait_next;

        // wake_req blocks go_idle, so a simultaneous request keeps RUN.
        assign w_go_idle = periph_en[gi] & ~recent_activity[gi] & ~wake_req[gi]
                         & w_thr_valid & (idle_count[gi] >= idle_threshold);
        assign w_timeout = (r_cnt >= C_TO_LAST);
        assign w_wait_next = (w_next == S_DRAIN) || (w_next == S_WAKE);

        always_comb begin
            w_next    = r_state;
            w_set_err = 1'b0;
            case (r_state)
                S_RUN: begin
                    if (w_go_idle) w_next = S_DRAIN;
                end
                S_DRAIN: begin
                    // Precedence: ack completion > abort > timeout.
                    if (!gate_ack[gi]) begin
                        w_next = S_GATED;
                    end else if (wake_req[gi] || recent_activity[gi] || !periph_en[gi]) begin
                        w_next = S_WAKE;
                    end else if (w_timeout) begin
                        w_next    = S_WAKE;
                        w_set_err = 1'b1;
                    end
                end
                S_GATED: begin
                    // idle_count and threshold are deliberately ignored here.
                    if (wake_req[gi] || !periph_en[gi]) w_next = S_WAKE;
                end
                S_WAKE: begin
                    if (gate_ack[gi]) begin
                        w_next = S_RUN;
                    end else if (w_timeout) begin
                        w_next    = S_RUN;
                        w_set_err = 1'b1;
                    end
                end
                default: w_next = S_RUN;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state   <= S_RUN;
                r_cnt     <= '0;
                r_gate_en <= 1'b1;
                r_gated   <= 1'b0;
                r_ack_err <= 1'b0;
            end else begin
                r_state   <= w_next;
                r_gate_en <= (w_next == S_RUN) || (w_next == S_WAKE);
                r_gated   <= (w_next == S_GATED);
                if (w_set_err) r_ack_err <= 1'b1;

                if (w_wait_next && (w_next != r_state)) begin
                    r_cnt <= '0;
                end else if (w_wait_next) begin
                    if (r_cnt != C_TO_SAT) r_cnt <= r_cnt + TW'(1);
                end else begin
                    r_cnt <= '0;
                end
            end
        end

        assign gate_en[gi] = r_gate_en;
        assign gated[gi]   = r_gated;
        assign ack_err[gi] = r_ack_err;

`ifdef POWER_GATE_STATS_EN
        logic [7:0] r_gcnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_gcnt <= 8'd0;
            end else if ((r_state == S_DRAIN) && (w_next == S_GATED) && (r_gcnt != 8'hFF)) begin
                r_gcnt <= r_gcnt + 8'd1;
            end
        end

        assign gate_count[gi] = r_gcnt;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_power_gate_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_power_gate_controller
// Description : Directed self-checking bench for power_gate_controller.
//               The gate_ack handshake partner is driven step by step.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_power_gate_controller;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int TO = 16;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N-1:0][W-1:0] idle_count;
    logic [N-1:0]        recent_activity;
    logic [N-1:0]        periph_en;
    logic [N-1:0]        wake_req;
    logic [W-1:0]        idle_threshold;
    logic [N-1:0]        gate_ack;
    logic [N-1:0]        gate_en;
    logic [N-1:0]        gated;
    logic [N-1:0]        ack_err;
`ifdef POWER_GATE_STATS_EN
    logic [N-1:0][7:0]   gate_count;
`endif

    int tests  = 0;
    int failed = 0;

    power_gate_controller #(.N(N), .W(W), .ACK_TIMEOUT(TO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .idle_count      (idle_count),
        .recent_activity (recent_activity),
        .periph_en       (periph_en),
        .wake_req        (wake_req),
        .idle_threshold  (idle_threshold),
        .gate_ack        (gate_ack),
        .gate_en         (gate_en),
        .gated           (gated),
`ifdef POWER_GATE_STATS_EN
        .gate_count      (gate_count),
`endif
        .ack_err         (ack_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full gate/wake cycle on peripheral 0 with an immediate ack.
    task automatic gate_cycle0();
        idle_count[0] = 16'd20;
        step();                              // RUN -> DRAIN
        gate_ack[0]   = 1'b0;
        idle_count[0] = 16'd0;
        step();                              // DRAIN -> GATED
        chk("cycle_gated", 32'(gated), 32'h1);
        wake_req[0] = 1'b1;
        step();                              // GATED -> WAKE
        wake_req[0] = 1'b0;
        gate_ack[0] = 1'b1;
        step();                              // WAKE -> RUN
        chk("cycle_run", 32'(gate_en), 32'hF);
    endtask

    initial begin
        rst_n           = 1'b0;
        idle_count      = '0;
        recent_activity = '0;
        periph_en       = '0;
        wake_req        = '0;
        idle_threshold  = 16'd20;
        gate_ack        = '0;

        // Reset with the gate reporting stopped clocks.
        step(); step();
        chk("rst_gate_en", 32'(gate_en), 32'hF);
        chk("rst_gated",   32'(gated),   32'h0);
        chk("rst_ack_err", 32'(ack_err), 32'h0);

        rst_n     = 1'b1;
        gate_ack  = 4'hF;
        periph_en = 4'hF;
        step();
        chk("run_idle", 32'(gate_en), 32'hF);

        // Gating periph 0: idle count ramps 18, 19, 20.
        idle_count[0] = 16'd18; step();
        chk("ramp18", 32'(gate_en), 32'hF);
        idle_count[0] = 16'd19; step();
        chk("ramp19", 32'(gate_en), 32'hF);
        idle_count[0] = 16'd20; step();
        chk("drain_gate_en", 32'(gate_en), 32'hE);
        chk("drain_gated",   32'(gated),   32'h0);
        step(); step();
        gate_ack[0] = 1'b0;
        step();
        chk("gated0", 32'(gated), 32'h1);
        chk("gated0_en", 32'(gate_en), 32'hE);
        step();
        chk("gated0_hold", 32'(gated), 32'h1);

        // Wake periph 0 with a one-cycle pulse; ack rises two cycles later.
        wake_req[0]   = 1'b1;
        idle_count[0] = 16'd0;
        step();
        wake_req[0] = 1'b0;
        chk("wake_en",    32'(gate_en), 32'hF);
        chk("wake_gated", 32'(gated),   32'h0);
        step(); step();
        gate_ack[0] = 1'b1;
        step();
        chk("wake_run_err", 32'(ack_err), 32'h0);
        chk("wake_run_en",  32'(gate_en), 32'hF);

        // Abort on periph 1 via recent activity while still in DRAIN.
        idle_count[1] = 16'd100;
        step();
        chk("abort_drain", 32'(gate_en), 32'hD);
        recent_activity[1] = 1'b1;
        idle_count[1]      = 16'd0;
        step();
        recent_activity[1] = 1'b0;
        chk("abort_wake_en", 32'(gate_en), 32'hF);
        chk("abort_gated",   32'(gated),   32'h0);
        step();
        chk("abort_run_gated", 32'(gated),   32'h0);
        chk("abort_no_err",    32'(ack_err), 32'h0);

        // Timeout on periph 2: ack never falls.
        idle_count[2] = 16'd500;
        step();
        chk("to_drain", 32'(gate_en), 32'hB);
        idle_count[2] = 16'd0;
        for (int k = 0; k < TO - 1; k++) step();
        chk("to_before", 32'(gate_en), 32'hB);
        chk("to_before_err", 32'(ack_err), 32'h0);
        step();
        chk("to_wake_en", 32'(gate_en), 32'hF);
        chk("to_err",     32'(ack_err), 32'h4);
        step();
        chk("to_err_sticky", 32'(ack_err), 32'h4);
        chk("to_gated",      32'(gated),   32'h0);

        // wake_req blocks go_idle on periph 3; then gate and disable it.
        idle_count[3] = 16'd50;
        wake_req[3]   = 1'b1;
        step();
        chk("wake_blocks", 32'(gate_en), 32'hF);
        wake_req[3] = 1'b0;
        step();
        chk("p3_drain", 32'(gate_en), 32'h7);
        gate_ack[3] = 1'b0;
        step();
        chk("p3_gated", 32'(gated), 32'h8);
        idle_threshold = 16'd0;           // must not release GATED
        step();
        chk("p3_thr_hold", 32'(gated), 32'h8);
        idle_threshold = 16'd20;
        periph_en[3]   = 1'b0;
        step();
        chk("p3_dis_wake", 32'(gate_en), 32'hF);
        chk("p3_dis_gated", 32'(gated), 32'h0);
        gate_ack[3]   = 1'b1;
        idle_count[3] = 16'd0;
        step();
        periph_en[3] = 1'b1;
        chk("p3_run", 32'(gate_en), 32'hF);

        // Threshold zero disables gating even at max idle count.
        idle_threshold = 16'd0;
        idle_count     = {N{16'hFFFF}};
        step(); step(); step();
        chk("thr0_en", 32'(gate_en), 32'hF);
        idle_count     = '0;
        idle_threshold = 16'd20;
        step();

        // Two more gate cycles on periph 0 (three in total).
        gate_cycle0();
        gate_cycle0();
`ifdef POWER_GATE_STATS_EN
        chk("gate_count0", 32'(gate_count[0]), 32'd3);
        chk("gate_count1", 32'(gate_count[1]), 32'd0);
`endif

        // Reset asserted mid-handshake forces RUN immediately.
        idle_count[0] = 16'd20;
        step();
        chk("pre_rst_drain", 32'(gate_en), 32'hE);
        rst_n = 1'b0;
        #1;
        chk("async_rst_en",  32'(gate_en), 32'hF);
        chk("async_rst_err", 32'(ack_err), 32'h0);
        idle_count[0] = 16'd0;
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_en", 32'(gate_en), 32'hF);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
